seg7_scan_display: RTL and testbench

SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

---
 rtl/seg7_scan_display.sv | 247 ++++++++++++++++++++++++
 tb/tb_seg7_scan_display.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: latches a binary value and shows it in hex or decimal on a
// multiplexed 7-segment display, with leading-zero blanking and overflow dashes.
//
// state  | meaning
// IDLE   | waiting for a load; hex loads commit straight from here
// CONV   | double-dabble running, one shift per cycle for DATA_W cycles
// COMMIT | converted digits (or a pending hex value) written to the display register
module seg7_scan_display #(
    parameter int DIGITS         = 3,
    parameter int DATA_W         = 8,
    parameter int DIV            = 8333,
    parameter int BLANK_CYC      = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit CA_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] binary,
    input  logic              load,
    input  logic              mode,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] ca,
    output logic              busy,
    output logic              overflow
);
    // BCD field always holds at least one digit beyond DIGITS so overflow is visible
    localparam int BCD_MIN = DATA_W * 3 / 10 + 1;
    localparam int BCD_N   = ((BCD_MIN > DIGITS) ? BCD_MIN : DIGITS) + 1;
    localparam int BCD_W   = 4 * BCD_N;
    localparam int SR_W    = BCD_W + DATA_W;
    localparam int HEX_W   = (DATA_W > 4 * DIGITS) ? DATA_W : 4 * DIGITS;
    localparam int PW      = $clog2(DIV);
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    typedef logic [DIGITS-1:0][3:0] digits_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] pbin_q, pbin_d;
    logic              pmode_q, pmode_d;
    digits_t           digits_q, digits_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] ca_q, ca_d;

    logic [DATA_W-1:0] eff_bin;
    logic              eff_mode, eff_valid;
    logic [BCD_W-1:0]  bcd;
    digits_t           dec_dig;
    logic              dec_ovf;
    logic [DIGITS-1:0] lz, sel_oh;
    logic              zero_above, cur_lz;
    logic [3:0]        cur;
    logic [6:0]        seg_raw;

    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_N; i++) begin
            if (r[DATA_W+4*i +: 4] >= 4'd5) r[DATA_W+4*i +: 4] = r[DATA_W+4*i +: 4] + 4'd3;
        end
        return r << 1;
    endfunction

    function automatic digits_t hex_digits(input logic [DATA_W-1:0] b);
        logic [HEX_W-1:0] p;
        digits_t          d;
        p = HEX_W'(b);
        for (int k = 0; k < DIGITS; k++) d[k] = p[4*k +: 4];
        return d;
    endfunction

    function automatic logic hex_ovf(input logic [DATA_W-1:0] b);
        logic [HEX_W-1:0] p;
        p = HEX_W'(b);
        return (p >> (4 * DIGITS)) != '0;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    always_comb begin
        bcd     = sr_q[DATA_W +: BCD_W];
        dec_dig = '0;
        for (int k = 0; k < DIGITS; k++) dec_dig[k] = bcd[4*k +: 4];
        dec_ovf = |bcd[BCD_W-1:4*DIGITS];
    end

    // A load arriving in COMMIT is folded in with the pending slot, newest wins
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        pend_d    = pend_q;
        pbin_d    = pbin_q;
        pmode_d   = pmode_q;
        digits_d  = digits_q;
        ovf_d     = ovf_q;
        eff_bin   = load ? binary : pbin_q;
        eff_mode  = load ? mode : pmode_q;
        eff_valid = load | pend_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (mode) begin
                        state_d = CONV;
                        cnt_d   = CW'(DATA_W - 1);
                        sr_d    = {{BCD_W{1'b0}}, binary};
                    end else begin
                        digits_d = hex_digits(binary);
                        ovf_d    = hex_ovf(binary);
                    end
                end
            end
            CONV: begin
                sr_d = dd_step(sr_q);
                if (cnt_q == '0) state_d = COMMIT;
                else             cnt_d   = cnt_q - CW'(1);
                if (load) begin
                    pend_d  = 1'b1;
                    pbin_d  = binary;
                    pmode_d = mode;
                end
            end
            COMMIT: begin
                pend_d = 1'b0;
                if (eff_valid && !eff_mode) begin
                    digits_d = hex_digits(eff_bin);
                    ovf_d    = hex_ovf(eff_bin);
                    state_d  = IDLE;
                end else begin
                    digits_d = dec_dig;
                    ovf_d    = dec_ovf;
                    if (eff_valid) begin
                        state_d = CONV;
                        cnt_d   = CW'(DATA_W - 1);
                        sr_d    = {{BCD_W{1'b0}}, eff_bin};
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Outputs are built from the next scan position so they line up with presc_q
    always_comb begin
        presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(DIV - 1)) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

        lz         = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (digits_q[k] == 4'd0);
            lz[k]      = zero_above;
        end

        cur    = 4'd0;
        cur_lz = 1'b0;
        sel_oh = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                cur       = digits_q[k];
                cur_lz    = lz[k];
                sel_oh[k] = 1'b1;
            end
        end

        if (ovf_q)                    seg_raw = 7'h40;
        else if (blank_lz && cur_lz)  seg_raw = 7'h00;
        else                          seg_raw = glyph(cur);

        if (presc_d < PW'(BLANK_CYC)) begin
            seg_raw = 7'h00;
            sel_oh  = '0;
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        ca_d  = CA_ACTIVE_LOW ? ~sel_oh : sel_oh;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            pend_q   <= 1'b0;
            pbin_q   <= '0;
            pmode_q  <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            seg_q    <= {7{SEG_ACTIVE_LOW}};
            ca_q     <= {DIGITS{CA_ACTIVE_LOW}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            pend_q   <= pend_d;
            pbin_q   <= pbin_d;
            pmode_q  <= pmode_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            ca_q     <= ca_d;
        end
    end

    assign seg      = seg_q;
    assign ca       = ca_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: table vectors, corner sequences and a random run
// against an event-level model of commits and scan position.
module tb_seg7_scan_display;
    localparam int D = 3, W = 8, DV = 4, BC = 1;

    logic clk, rstn, load, mode, blank_lz;
    logic [W-1:0] binary;
    logic [6:0] seg;
    logic [D-1:0] ca;
    logic busy, overflow;
    logic load2, mode2, blz2, busy2, ovf2;
    logic [7:0] bin2;
    logic [6:0] seg2;
    logic [0:0] ca2;

    int checks = 0;
    int errors = 0;

    seg7_scan_display #(.DIGITS(D), .DATA_W(W), .DIV(DV), .BLANK_CYC(BC)) dut (
        .clk(clk), .rstn(rstn), .binary(binary), .load(load), .mode(mode),
        .blank_lz(blank_lz), .seg(seg), .ca(ca), .busy(busy), .overflow(overflow));

    seg7_scan_display #(.DIGITS(1), .DATA_W(8), .DIV(DV), .BLANK_CYC(BC)) dut2 (
        .clk(clk), .rstn(rstn), .binary(bin2), .load(load2), .mode(mode2),
        .blank_lz(blz2), .seg(seg2), .ca(ca2), .busy(busy2), .overflow(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // model: display contents plus a schedule of when the next commit lands
    int m_n, m_dig [D], m_commit_edge, m_conv_val, m_pbin;
    bit m_dash, m_active, m_pend, m_pmode;
    logic [6:0] e_seg;
    logic [D-1:0] e_ca;
    bit e_busy, e_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_n = 0; m_dash = 0; m_active = 0; m_pend = 0;
        for (int k = 0; k < D; k++) m_dig[k] = 0;
    endtask

    task automatic m_commit(input int v, input bit dec);
        int base;
        base = dec ? 10 : 16;
        for (int k = 0; k < D; k++) begin
            m_dig[k] = v % base;
            v = v / base;
        end
        m_dash = (v != 0);
    endtask

    task automatic m_edge();
        int idx, presc, eb;
        bit lzb, em, ev;
        logic [D-1:0] oh;
        m_n++;
        presc = m_n % DV;
        idx = (m_n / DV) % D;
        if (presc < BC) begin
            e_seg = 7'h00;
            e_ca = '1;
        end else begin
            oh = '0;
            oh[idx] = 1'b1;
            e_ca = ~oh;
            lzb = blank_lz && idx > 0;
            for (int k = idx; k < D; k++) if (m_dig[k] != 0) lzb = 0;
            if (m_dash) e_seg = 7'h40;
            else if (lzb) e_seg = 7'h00;
            else e_seg = GLY[m_dig[idx]];
        end
        if (!m_active) begin
            if (load) begin
                if (mode) begin
                    m_active = 1; m_conv_val = int'(binary); m_commit_edge = m_n + W + 1;
                end else m_commit(int'(binary), 0);
            end
        end else if (m_n < m_commit_edge) begin
            if (load) begin m_pend = 1; m_pbin = int'(binary); m_pmode = mode; end
        end else begin
            if (load) begin eb = int'(binary); em = mode; ev = 1; end
            else begin eb = m_pbin; em = m_pmode; ev = m_pend; end
            m_pend = 0;
            if (ev && !em) begin
                m_commit(eb, 0);
                m_active = 0;
            end else begin
                m_commit(m_conv_val, 1);
                if (ev) begin m_conv_val = eb; m_commit_edge = m_n + W + 1; end
                else m_active = 0;
            end
        end
        e_busy = m_active;
        e_ovf = m_dash;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
        chk("seg", seg, e_seg);
        chk("ca", ca, e_ca);
        chk("busy", busy, e_busy);
        chk("overflow", overflow, e_ovf);
    endtask

    logic [6:0] cap [D];
    logic [6:0] cap2;
    int nbusy, nbusy2, n_s0_one, n_s2_one;

    task automatic run_cap(input int ncyc);
        logic [D-1:0] oh;
        for (int k = 0; k < D; k++) cap[k] = 'x;
        cap2 = 'x;
        nbusy = 0; nbusy2 = 0; n_s0_one = 0; n_s2_one = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (i == 0) begin load = 1'b0; load2 = 1'b0; end
            if (busy) nbusy++;
            if (busy2) nbusy2++;
            for (int k = 0; k < D; k++) begin
                oh = '0;
                oh[k] = 1'b1;
                if (ca == ~oh) cap[k] = seg;
            end
            if (ca == 3'b110 && seg == 7'h06) n_s0_one++;
            if (ca == 3'b011 && seg == 7'h06) n_s2_one++;
            if (ca2 == 1'b0) cap2 = seg2;
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((busy || m_active) && i < 100) begin tick(); i++; end
        chk("wait_idle", busy, 0);
    endtask

    typedef struct {
        bit         md;
        logic [7:0] bin;
        bit         blz;
        logic [6:0] s0, s1, s2;
        bit         ov;
    } vec_t;
    vec_t vt [12];

    initial begin
        vt[0]  = '{1'b0, 8'hA5, 1'b0, 7'h6D, 7'h77, 7'h3F, 1'b0};
        vt[1]  = '{1'b1, 8'd255, 1'b0, 7'h6D, 7'h6D, 7'h5B, 1'b0};
        vt[2]  = '{1'b1, 8'd7, 1'b1, 7'h07, 7'h00, 7'h00, 1'b0};
        vt[3]  = '{1'b1, 8'd100, 1'b1, 7'h3F, 7'h3F, 7'h06, 1'b0};
        vt[4]  = '{1'b0, 8'h0F, 1'b1, 7'h71, 7'h00, 7'h00, 1'b0};
        vt[5]  = '{1'b0, 8'h08, 1'b0, 7'h7F, 7'h3F, 7'h3F, 1'b0};
        vt[6]  = '{1'b1, 8'd99, 1'b1, 7'h6F, 7'h6F, 7'h00, 1'b0};
        vt[7]  = '{1'b1, 8'd0, 1'b1, 7'h3F, 7'h00, 7'h00, 1'b0};
        vt[8]  = '{1'b1, 8'd128, 1'b0, 7'h7F, 7'h5B, 7'h06, 1'b0};
        vt[9]  = '{1'b0, 8'h3C, 1'b1, 7'h39, 7'h4F, 7'h00, 1'b0};
        vt[10] = '{1'b1, 8'd64, 1'b0, 7'h66, 7'h7D, 7'h3F, 1'b0};
        vt[11] = '{1'b0, 8'hE0, 1'b1, 7'h3F, 7'h79, 7'h00, 1'b0};

        rstn = 1'b0; load = 1'b0; mode = 1'b0; blank_lz = 1'b0; binary = '0;
        load2 = 1'b0; mode2 = 1'b0; blz2 = 1'b0; bin2 = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_seg", seg, 7'h00);
        chk("rst_ca", ca, 3'b111);
        chk("rst_ca2", ca2, 1'b1);
        chk("rst_ovf2", ovf2, 0);
        @(negedge clk);
        rstn = 1'b1;
        m_reset();
        #1;
        chk("first_slot_blank", ca, 3'b111);

        // single-digit build: hex and decimal overflow rules
        bin2 = 8'h10; mode2 = 1'b0; load2 = 1'b1; run_cap(8);
        chk("d1_hex10_seg", cap2, 7'h40);
        chk("d1_hex10_ovf", ovf2, 1);
        chk("d1_hex10_busy", nbusy2, 0);
        bin2 = 8'd9; mode2 = 1'b1; load2 = 1'b1; run_cap(W + 2 + DV + 2);
        chk("d1_dec9_seg", cap2, 7'h6F);
        chk("d1_dec9_ovf", ovf2, 0);
        chk("d1_dec9_busy", nbusy2, W + 1);
        bin2 = 8'd10; mode2 = 1'b1; load2 = 1'b1; run_cap(W + 2 + DV + 2);
        chk("d1_dec10_seg", cap2, 7'h40);
        chk("d1_dec10_ovf", ovf2, 1);
        bin2 = 8'h0F; mode2 = 1'b0; load2 = 1'b1; run_cap(8);
        chk("d1_hex0f_seg", cap2, 7'h71);
        chk("d1_hex0f_ovf", ovf2, 0);

        for (int v = 0; v < 12; v++) begin
            wait_idle();
            blank_lz = vt[v].blz;
            binary = vt[v].bin; mode = vt[v].md; load = 1'b1;
            run_cap(W + 2 + D * DV + 2);
            chk($sformatf("vec%0d_slot0", v), cap[0], vt[v].s0);
            chk($sformatf("vec%0d_slot1", v), cap[1], vt[v].s1);
            chk($sformatf("vec%0d_slot2", v), cap[2], vt[v].s2);
            chk($sformatf("vec%0d_ovf", v), overflow, vt[v].ov);
            chk($sformatf("vec%0d_busycyc", v), nbusy, vt[v].md ? W + 1 : 0);
        end

        // two loads while busy: the first is overwritten and never displayed
        wait_idle();
        blank_lz = 1'b0;
        binary = 8'h00; mode = 1'b0; load = 1'b1; run_cap(2);
        binary = 8'd100; mode = 1'b1; load = 1'b1; tick(); load = 1'b0; tick();
        binary = 8'd1; load = 1'b1; tick(); load = 1'b0; tick();
        binary = 8'd42; load = 1'b1;
        run_cap(2 * (W + 2) + D * DV + 4);
        chk("pend_never_1", n_s0_one, 0);
        chk("pend_saw_100", n_s2_one > 0, 1);
        chk("pend_slot0", cap[0], 7'h5B);
        chk("pend_slot1", cap[1], 7'h66);
        chk("pend_slot2", cap[2], 7'h3F);

        // hex load landing in the COMMIT cycle replaces the converted result
        wait_idle();
        binary = 8'd200; mode = 1'b1; load = 1'b1; tick(); load = 1'b0;
        repeat (W) tick();
        binary = 8'h21; mode = 1'b0; load = 1'b1;
        run_cap(D * DV + 4);
        chk("commit_hex_slot0", cap[0], 7'h06);
        chk("commit_hex_slot1", cap[1], 7'h5B);
        chk("commit_hex_slot2", cap[2], 7'h3F);
        chk("commit_hex_busy", nbusy, 0);

        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 5) == 0);
            mode = 1'($urandom);
            binary = 8'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            tick();
        end
        load = 1'b0;

        // reset in the middle of a conversion with a load pending
        wait_idle();
        blank_lz = 1'b0;
        binary = 8'h5A; mode = 1'b0; load = 1'b1; run_cap(2);
        binary = 8'd153; mode = 1'b1; load = 1'b1; tick(); load = 1'b0;
        tick();
        binary = 8'd77; load = 1'b1; tick(); load = 1'b0;
        tick();
        #1 rstn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ca", ca, 3'b111);
        chk("midrst_seg", seg, 7'h00);
        chk("midrst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        m_reset();
        run_cap(40);
        chk("post_rst_busy", nbusy, 0);
        chk("post_rst_slot0", cap[0], 7'h3F);
        chk("post_rst_slot1", cap[1], 7'h3F);
        chk("post_rst_slot2", cap[2], 7'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
